// File: rtl/id_pkg.sv
// id_pkg: shared types and helpers for the ID-stage scoreboard.
//   sb_entry_t  : one in-flight producer {valid, rw, cnt}
//   SEL_REGFILE : operand select value meaning "read the register file"
//   sel_w()     : width of a forwarding select for a given scoreboard depth
// The entry field widths follow the default NREG/LAT_W; a build that changes
// those parameters must change ID_NREG/ID_LAT_W here to match.
package id_pkg;
  localparam int ID_NREG     = 32;
  localparam int ID_AW       = $clog2(ID_NREG);
  localparam int ID_LAT_W    = 3;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic [ID_AW-1:0]    rw;
    logic [ID_LAT_W-1:0] cnt;   // cycles left until the result is forwardable
  } sb_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/id_scoreboard_sb_match.sv
// sb_match: priority matcher of one source operand against the scoreboard.
//   src, use_src : source register and whether it is actually read
//   ents         : scoreboard entries, index 0 = youngest (EX)
//   hazard       : source must wait (result not yet forwardable)
//   sel          : 0 = register file, k = forward from entry k-1
// Macro ID_SB_FWD_EN: when undefined, every match is a hazard and sel stays 0.
module sb_match
  import id_pkg::*;
#(
  parameter int DEPTH = 3
)(
  input  logic                     [ID_AW-1:0] src,
  input  logic                                 use_src,
  input  sb_entry_t                [DEPTH-1:0] ents,
  output logic                                 hazard,
  output logic        [sel_w(DEPTH)-1:0]       sel
);
  localparam int SW = sel_w(DEPTH);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hazard = 1'b0;
    sel    = SW'(SEL_REGFILE);
    if (use_src && src != '0) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (ents[i].valid && ents[i].rw == src) begin
`ifdef ID_SB_FWD_EN
          if (ents[i].cnt == '0) begin
            hazard = 1'b0;
            sel    = SW'(i + 1);
          end else begin
            hazard = 1'b1;
            sel    = SW'(SEL_REGFILE);
          end
`else
          hazard = 1'b1;
`endif
        end
      end
    end
  end

`ifndef ID_SB_FWD_EN
  logic unused_ents;
  assign unused_ents = ^ents;
`endif
endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: ID-stage hazard and forwarding unit built on a shift-register
// scoreboard of DEPTH in-flight destinations (entry 0 = EX ... DEPTH-1 = WB).
//   clk, reset        : clock, synchronous active-high reset
//   id_valid          : ID instruction is real
//   rs/rt, use_rs/rt  : source fields and their read enables
//   rw, wr_en, lat    : destination, write enable, forwarding latency
//   flush             : kill in-flight entries and the ID instruction
//   stall             : hold IF/ID, bubble into EX
//   op_a_sel/op_b_sel : 0 = register file, k = forward from entry k-1
//   busy              : any valid entry
// Macro ID_SB_FWD_EN enables forwarding and the countdown; without it,
// consumers wait until the producer retires and read the register file.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = ID_NREG,
  parameter int DEPTH = 3,
  parameter int LAT_W = ID_LAT_W
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [$clog2(NREG)-1:0]    rs,
  input  logic [$clog2(NREG)-1:0]    rt,
  input  logic                       use_rs,
  input  logic                       use_rt,
  input  logic [$clog2(NREG)-1:0]    rw,
  input  logic                       wr_en,
  input  logic [LAT_W-1:0]           lat,
  input  logic                       flush,
  output logic                       stall,
  output logic [sel_w(DEPTH)-1:0]    op_a_sel,
  output logic [sel_w(DEPTH)-1:0]    op_b_sel,
  output logic                       busy
);
  // XLEN only exists so the parameter set matches the rest of the pipeline.
  if (XLEN <= 0) begin : g_xlen_unused
  end

  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t             push_ent;
  logic                  push, haz_a, haz_b;

  sb_match #(.DEPTH(DEPTH)) u_match_a (
    .src(ID_AW'(rs)), .use_src(use_rs), .ents(sb_q), .hazard(haz_a), .sel(op_a_sel)
  );
  sb_match #(.DEPTH(DEPTH)) u_match_b (
    .src(ID_AW'(rt)), .use_src(use_rt), .ents(sb_q), .hazard(haz_b), .sel(op_b_sel)
  );

  assign stall = (haz_a | haz_b) & id_valid & ~flush;
  // Push depends on stall, never the reverse, so no comb loop.
  assign push  = id_valid & wr_en & (rw != '0) & ~stall & ~flush;

  always_comb begin
    push_ent       = '0;
    push_ent.valid = push;
    push_ent.rw    = ID_AW'(rw);
`ifdef ID_SB_FWD_EN
    push_ent.cnt   = ID_LAT_W'(lat);
`endif
  end

`ifndef ID_SB_FWD_EN
  logic unused_lat;
  assign unused_lat = ^lat;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sb_q <= '0;
    end else begin
      sb_q[0] <= push_ent;
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i].valid <= sb_q[i-1].valid;
        sb_q[i].rw    <= sb_q[i-1].rw;
`ifdef ID_SB_FWD_EN
        sb_q[i].cnt   <= (sb_q[i-1].cnt == '0) ? '0 : sb_q[i-1].cnt - 1'b1;
`else
        sb_q[i].cnt   <= '0;
`endif
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | sb_q[i].valid;
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenarios plus randomized traffic checked against
// a history-based model (each producer remembered by issue cycle and latency).
module tb_id_scoreboard;
  localparam int DEPTH = 3;
  localparam int NREG  = 32;
  localparam int LAT_W = 3;
  localparam int AW    = 5;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic reset, id_valid, use_rs, use_rt, wr_en, flush;
  logic [AW-1:0] rs, rt, rw;
  logic [LAT_W-1:0] lat;
  logic stall, busy;
  logic [SW-1:0] op_a_sel, op_b_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_scoreboard #(.XLEN(32), .NREG(NREG), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .rw(rw), .wr_en(wr_en), .lat(lat),
    .flush(flush), .stall(stall), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
    .busy(busy)
  );

  // ---------------- reference model ----------------
  // A producer issued at cycle c has age (now - c - 1) stages past ID; it is
  // visible while age < DEPTH and forwardable once age >= lat.
  int h_rw[$];
  int h_lat[$];
  int h_cyc[$];
  int cyc = 0;
  bit m_stall, m_busy;
  int m_sel_a, m_sel_b;

  function automatic void mdl_src(input int src, input bit u, output bit hz, output int sel);
    hz = 1'b0;
    sel = 0;
    if (!u || src == 0) return;
    for (int k = h_rw.size() - 1; k >= 0; k--) begin
      int age;
      age = cyc - h_cyc[k] - 1;
      if (age < DEPTH && h_rw[k] == src) begin
`ifdef ID_SB_FWD_EN
        if (age >= h_lat[k]) sel = age + 1;
        else hz = 1'b1;
`else
        hz = 1'b1;
`endif
        return;
      end
    end
  endfunction

  function automatic void mdl_eval();
    bit ha, hb;
    mdl_src(int'(rs), use_rs, ha, m_sel_a);
    mdl_src(int'(rt), use_rt, hb, m_sel_b);
    m_stall = (ha | hb) & id_valid & ~flush;
    m_busy = 1'b0;
    foreach (h_cyc[k]) if (cyc - h_cyc[k] - 1 < DEPTH) m_busy = 1'b1;
  endfunction

  task automatic tick();
    mdl_eval();
    if (reset || flush) begin
      h_rw.delete(); h_lat.delete(); h_cyc.delete();
    end else if (id_valid && wr_en && rw != '0 && !m_stall) begin
      h_rw.push_back(int'(rw)); h_lat.push_back(int'(lat)); h_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    while (h_cyc.size() > 0 && cyc - h_cyc[0] - 1 >= DEPTH) begin
      void'(h_rw.pop_front()); void'(h_lat.pop_front()); void'(h_cyc.pop_front());
    end
    #1;
  endtask

  task automatic drive(input bit iv, input int s_rs, input bit u_rs, input int s_rt,
                       input bit u_rt, input int d_rw, input bit wen, input int l, input bit fl);
    id_valid = iv; rs = AW'(s_rs); use_rs = u_rs; rt = AW'(s_rt); use_rt = u_rt;
    rw = AW'(d_rw); wr_en = wen; lat = LAT_W'(l); flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 2) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++;
      if (stall !== 1'b0 || op_a_sel !== '0 || op_b_sel !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: stall=%b sel_a=%0d sel_b=%0d busy=%b, expected all 0",
                 i, stall, op_a_sel, op_b_sel, busy);
      end
      tick();
    end
  endtask

  task automatic test_alu_fwd();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    checks++;
`ifdef ID_SB_FWD_EN
    if (stall !== 1'b0 || op_a_sel !== 2'd1) begin
      errors++;
      $display("FAIL alu_fwd_e0: stall=%b sel_a=%0d, expected stall=0 sel_a=1", stall, op_a_sel);
    end
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || op_a_sel !== 2'd2) begin
      errors++;
      $display("FAIL alu_fwd_e1: stall=%b sel_a=%0d, expected stall=0 sel_a=2", stall, op_a_sel);
    end
`else
    if (stall !== 1'b1 || op_a_sel !== 2'd0) begin
      errors++;
      $display("FAIL alu_nofwd: stall=%b sel_a=%0d, expected stall=1 sel_a=0", stall, op_a_sel);
    end
`endif
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
`ifdef ID_SB_FWD_EN
    checks++;
    if (stall !== 1'b1 || op_b_sel !== 2'd0) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b sel_b=%0d, expected stall=1 sel_b=0", stall, op_b_sel);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || op_b_sel !== 2'd2) begin
      errors++;
      $display("FAIL load_use_fwd: stall=%b sel_b=%0d, expected stall=0 sel_b=2", stall, op_b_sel);
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (stall !== 1'b1 || op_b_sel !== 2'd0) begin
        errors++;
        $display("FAIL load_use_stall[%0d]: stall=%b sel_b=%0d, expected stall=1 sel_b=0", i, stall, op_b_sel);
      end
      tick();
    end
    checks++;
    if (stall !== 1'b0 || op_b_sel !== 2'd0) begin
      errors++;
      $display("FAIL load_use_retired: stall=%b sel_b=%0d, expected stall=0 sel_b=0", stall, op_b_sel);
    end
`endif
    drain();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 0, 0, 7, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || op_b_sel !== 2'd0) begin
      errors++;
      $display("FAIL load_imm_operand: stall=%b sel_b=%0d, expected stall=0 sel_b=0", stall, op_b_sel);
    end
    drain();
  endtask

  task automatic test_youngest();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    checks++;
`ifdef ID_SB_FWD_EN
    if (stall !== 1'b0 || op_a_sel !== 2'd1) begin
      errors++;
      $display("FAIL youngest_wins: stall=%b sel_a=%0d, expected stall=0 sel_a=1", stall, op_a_sel);
    end
`else
    if (stall !== 1'b1 || op_a_sel !== 2'd0) begin
      errors++;
      $display("FAIL youngest_nofwd: stall=%b sel_a=%0d, expected stall=1 sel_a=0", stall, op_a_sel);
    end
`endif
    drain();
  endtask

  task automatic test_long_lat();
    drive(1, 0, 0, 0, 0, 9, 1, 4, 0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1 || op_a_sel !== 2'd0) begin
        errors++;
        $display("FAIL long_lat_stall[%0d]: stall=%b sel_a=%0d, expected stall=1 sel_a=0", i, stall, op_a_sel);
      end
      tick();
    end
    checks++;
    if (stall !== 1'b0 || op_a_sel !== 2'd0) begin
      errors++;
      $display("FAIL long_lat_retired: stall=%b sel_a=%0d, expected stall=0 sel_a=0", stall, op_a_sel);
    end
    drain();
  endtask

  task automatic test_flush_r0();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 0, 0, 7, 1, 12, 1, 0, 0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_stall: stall=%b, expected 1", stall);
    end
    drive(1, 0, 0, 7, 1, 12, 1, 0, 1);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_stall: stall=%b, expected 0", stall);
    end
    tick();
    idle();
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_clears: stall=%b busy=%b, expected stall=0 busy=0", stall, busy);
    end
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || op_a_sel !== 2'd0) begin
      errors++;
      $display("FAIL flush_no_push: stall=%b sel_a=%0d, expected stall=0 sel_a=0", stall, op_a_sel);
    end
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || op_a_sel !== 2'd0 || op_b_sel !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL r0_never: stall=%b sel_a=%0d sel_b=%0d busy=%b, expected all 0",
               stall, op_a_sel, op_b_sel, busy);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: stall=%b, expected 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: stall=%b busy=%b, expected stall=0 busy=0", stall, busy);
    end
    drain();
  endtask

  task automatic test_random();
    bit [SW-1:0] ea, eb;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 15) == 0);
      mdl_eval();
      ea = m_sel_a[SW-1:0];
      eb = m_sel_b[SW-1:0];
      checks++;
      if (stall !== m_stall || op_a_sel !== ea || op_b_sel !== eb || busy !== m_busy) begin
        errors++;
        $display("FAIL random[%0d]: stall=%b sel_a=%0d sel_b=%0d busy=%b, expected stall=%b sel_a=%0d sel_b=%0d busy=%b",
                 i, stall, op_a_sel, op_b_sel, busy, m_stall, ea, eb, m_busy);
      end
      tick();
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_long_lat();
    test_flush_r0();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
